// File: rtl/uart_pkg.sv
// Shared types, CRC-8 constants and the CRC update helper
// for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // MSB-first CRC-8 over the low nbits of data.
  function automatic logic [7:0] crc8_update(
    input logic [7:0] crc,
    input logic [8:0] data,
    input int         nbits
  );
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 8; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[7] ^ data[i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ CRC8_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side ready/valid port of the UART TX FIFO.
// master drives valid/data, slave returns ready.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ready_o;

  modport master (
    output wr_valid_i,
    output wr_data_i,
    input  wr_ready_o
  );

  modport slave (
    input  wr_valid_i,
    input  wr_data_i,
    output wr_ready_o
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO: push/pop, full/empty flags and level.
// Ports: clk_i, rst_i, push_i, data_i, pop_i, data_o, full_o, empty_o, level_o.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LVL_W-1:0]  r_cnt;
  logic              w_push;
  logic              w_pop;

  assign full_o  = (r_cnt == LVL_W'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign level_o = r_cnt;
  assign data_o  = r_mem[r_rptr];
  // No bypass: a write while full is dropped.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + LVL_W'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - LVL_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO, runtime parity/stop, CRC-8 burst trailer.
// Ports: clk_i, rst_i, trigger_i, config, wr (ready/valid), level, ovf, busy, tx, irq.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trigger_i,
  input  logic             tx_en_i,
  input  logic             crc_en_i,
  input  logic [1:0]       parity_mode_i,
  input  logic             stop2_i,
  uart_tx_fifo_if.slave    wr,
  output logic [LVL_W-1:0] fifo_level_o,
  input  logic             ovf_clr_i,
  output logic             ovf_o,
  output logic             busy_o,
  output logic             tx_o,
  output logic             tx_int_o
);
  tx_state_e         r_state, w_state_nxt;
  parity_mode_e      r_par_mode;
  logic [8:0]        r_shift;
  logic [3:0]        r_cnt;
  logic [3:0]        r_nbits;
  logic              r_par;
  logic              r_stop2;
  logic              r_stop_cnt;
  logic              r_crc_en;
  logic              r_is_crc;
  logic [7:0]        r_crc;
  logic              r_tx;
  logic              r_busy;
  logic              r_int;
  logic              r_ovf;
  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_load_crc;
  logic              w_finish;
  logic              w_shift;
  logic              w_stop_hold;
  logic              w_tx_nxt;
  logic              w_par_on;
  logic              w_par_bit;

  uart_sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (wr.wr_valid_i),
    .data_i (wr.wr_data_i),
    .pop_i  (w_pop),
    .data_o (w_head),
    .full_o (w_full),
    .empty_o(w_empty),
    .level_o(fifo_level_o)
  );

  assign wr.wr_ready_o = !w_full;
  assign ovf_o         = r_ovf;
  assign busy_o        = r_busy;
  assign tx_o          = r_tx;
  assign tx_int_o      = r_int;
  assign w_par_on  = (r_par_mode == PAR_EVEN) ||
                     (r_par_mode == PAR_ODD);
  assign w_par_bit = (r_par_mode == PAR_ODD) ? ~r_par : r_par;

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    w_load_crc  = 1'b0;
    w_finish    = 1'b0;
    w_shift     = 1'b0;
    w_stop_hold = 1'b0;
    if (trigger_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (tx_en_i && !w_empty) begin
            w_pop       = 1'b1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          w_shift     = 1'b1;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end
        S_DATA: begin
          if (r_cnt == r_nbits) begin
            if (w_par_on) begin
              w_tx_nxt    = w_par_bit;
              w_state_nxt = S_PARITY;
            end else begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = S_STOP;
            end
          end else begin
            w_shift  = 1'b1;
            w_tx_nxt = r_shift[0];
          end
        end
        S_PARITY: begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_hold = 1'b1;
          end else if (!r_is_crc && tx_en_i && !w_empty) begin
            w_pop       = 1'b1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else if (!r_is_crc && r_crc_en) begin
            w_load_crc  = 1'b1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_finish    = 1'b1;
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_par_mode <= PAR_NONE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_nbits    <= '0;
      r_par      <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_crc_en   <= 1'b0;
      r_is_crc   <= 1'b0;
      r_crc      <= CRC8_INIT;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_int      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_int   <= w_finish;
      if (trigger_i) r_stop_cnt <= w_stop_hold;
      // Set has priority over clear.
      if (wr.wr_valid_i && w_full) r_ovf <= 1'b1;
      else if (ovf_clr_i)          r_ovf <= 1'b0;
      if (w_pop) begin
        r_shift    <= 9'(w_head);
        r_cnt      <= '0;
        r_nbits    <= 4'(DATA_W);
        r_par      <= ^w_head;
        r_par_mode <= parity_mode_e'(parity_mode_i);
        r_stop2    <= stop2_i;
        r_crc      <= crc8_update(r_crc, 9'(w_head), DATA_W);
        r_is_crc   <= 1'b0;
        r_busy     <= 1'b1;
        // CRC enable is sampled only when a burst starts.
        if (r_state == S_IDLE) r_crc_en <= crc_en_i;
      end
      if (w_load_crc) begin
        r_shift  <= {1'b0, r_crc};
        r_cnt    <= '0;
        r_nbits  <= 4'd8;
        r_par    <= ^r_crc;
        r_is_crc <= 1'b1;
      end
      if (w_shift) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + 4'd1;
      end
      if (w_finish) begin
        r_busy   <= 1'b0;
        r_crc    <= CRC8_INIT;
        r_crc_en <= 1'b0;
        r_is_crc <= 1'b0;
      end
    end
  end

endmodule
